// File: rtl/fetch_sequencer.sv
// fetch_sequencer: multi-cycle instruction fetch controller.
// Drives the PC control strobes and runs the imem request/ack handshake.
// Fetched words are held in a one-entry buffer that decode drains with
// valid/ready. Execute-stage redirects flush the buffer and any fetch in flight.
module fetch_sequencer #(
    parameter int TIMEOUT = 255,
    parameter int CNT_W   = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [31:0]      pc_value,
    output logic             pc_incr_en,
    output logic             pc_write_en,
    output logic             pc_branch,
    output logic             imem_req,
    output logic [31:0]      imem_addr,
    input  logic             imem_ack,
    input  logic [31:0]      imem_rdata,
    output logic             instr_valid,
    output logic [31:0]      instr_data,
    output logic [31:0]      instr_pc,
    input  logic             instr_ready,
    input  logic             redirect_valid,
    input  logic             redirect_is_imm,
    input  logic             halt,
    output logic             fetch_err,
    output logic [CNT_W-1:0] fetch_count
);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        FETCH  = 3'd1,
        ISSUE  = 3'd2,
        DRAIN  = 3'd3,
        HALTED = 3'd4,
        ERROR  = 3'd5
    } state_t;

    // Last wait-counter value before the timeout fires (counter starts at 0).
    localparam logic [7:0] WAIT_LAST = 8'(TIMEOUT - 1);

    state_t     state;
    logic [7:0] wait_cnt;
    logic       redirect_act;
    logic       wait_expired;

    // PC strobes and memory request are decoded from state and live inputs;
    // redirect wins over increment, and reset silences everything.
    always_comb begin
        redirect_act = !reset && redirect_valid && (state != IDLE) && (state != ERROR);
        pc_branch    = redirect_act && redirect_is_imm;
        pc_write_en  = redirect_act && !redirect_is_imm;
        pc_incr_en   = !reset && (state == FETCH) && imem_ack && !redirect_valid;
        imem_req     = !reset && (state == FETCH);
        imem_addr    = imem_req ? pc_value : 32'd0;
        wait_expired = (wait_cnt == WAIT_LAST);
    end

    // Fetch state machine with its registered buffer, error flag and counters.
    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            wait_cnt    <= 8'd0;
            instr_valid <= 1'b0;
            instr_data  <= 32'd0;
            instr_pc    <= 32'd0;
            fetch_err   <= 1'b0;
            fetch_count <= '0;
        end else begin
            case (state)
                IDLE: begin
                    wait_cnt <= 8'd0;
                    state    <= halt ? HALTED : FETCH;
                end
                FETCH: begin
                    if (redirect_valid) begin
                        // With an ack this cycle the word is simply dropped;
                        // otherwise the outstanding response must be drained.
                        wait_cnt <= 8'd0;
                        state    <= imem_ack ? FETCH : DRAIN;
                    end else if (imem_ack) begin
                        instr_data  <= imem_rdata;
                        instr_pc    <= pc_value;
                        instr_valid <= 1'b1;
                        state       <= ISSUE;
                    end else if (wait_expired) begin
                        fetch_err <= 1'b1;
                        state     <= ERROR;
                    end else begin
                        wait_cnt <= wait_cnt + 8'd1;
                    end
                end
                ISSUE: begin
                    if (redirect_valid) begin
                        instr_valid <= 1'b0;
                        wait_cnt    <= 8'd0;
                        state       <= FETCH;
                    end else if (instr_ready) begin
                        instr_valid <= 1'b0;
                        fetch_count <= fetch_count + {{(CNT_W-1){1'b0}}, 1'b1};
                        wait_cnt    <= 8'd0;
                        state       <= halt ? HALTED : FETCH;
                    end
                end
                DRAIN: begin
                    // A redirect here only re-strobes the PC; the stale ack
                    // still has to be swallowed before fetching resumes.
                    if (imem_ack) begin
                        wait_cnt <= 8'd0;
                        state    <= FETCH;
                    end else if (wait_expired) begin
                        fetch_err <= 1'b1;
                        state     <= ERROR;
                    end else begin
                        wait_cnt <= wait_cnt + 8'd1;
                    end
                end
                HALTED: begin
                    if (!halt) begin
                        wait_cnt <= 8'd0;
                        state    <= FETCH;
                    end
                end
                ERROR: begin
                    state <= ERROR;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fetch_sequencer.sv
// tb_fetch_sequencer: directed bench for fetch_sequencer with a
// transaction-level reference model checked every cycle.
module tb_fetch_sequencer;

    localparam int TIMEOUT = 4;
    localparam int CNT_W   = 3;
    localparam logic [31:0] STALE = 32'hDEAD_BEEF;

    logic             clk = 1'b0;
    logic             reset = 1'b1;
    logic [31:0]      pc_value = 32'd0;
    logic             pc_incr_en;
    logic             pc_write_en;
    logic             pc_branch;
    logic             imem_req;
    logic [31:0]      imem_addr;
    logic             imem_ack = 1'b0;
    logic [31:0]      imem_rdata = 32'd0;
    logic             instr_valid;
    logic [31:0]      instr_data;
    logic [31:0]      instr_pc;
    logic             instr_ready = 1'b0;
    logic             redirect_valid = 1'b0;
    logic             redirect_is_imm = 1'b0;
    logic             halt = 1'b0;
    logic             fetch_err;
    logic [CNT_W-1:0] fetch_count;

    fetch_sequencer #(.TIMEOUT(TIMEOUT), .CNT_W(CNT_W)) dut (
        .clk             (clk),
        .reset           (reset),
        .pc_value        (pc_value),
        .pc_incr_en      (pc_incr_en),
        .pc_write_en     (pc_write_en),
        .pc_branch       (pc_branch),
        .imem_req        (imem_req),
        .imem_addr       (imem_addr),
        .imem_ack        (imem_ack),
        .imem_rdata      (imem_rdata),
        .instr_valid     (instr_valid),
        .instr_data      (instr_data),
        .instr_pc        (instr_pc),
        .instr_ready     (instr_ready),
        .redirect_valid  (redirect_valid),
        .redirect_is_imm (redirect_is_imm),
        .halt            (halt),
        .fetch_err       (fetch_err),
        .fetch_count     (fetch_count)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return 32'hE000_0000 | a;
    endfunction

    // Reference model: fetch progress kept as independent flags plus the buffer.
    logic        m_idle = 1'b1;
    logic        m_fetching = 1'b0;
    logic        m_draining = 1'b0;
    logic        m_halted = 1'b0;
    logic        m_err = 1'b0;
    logic        m_buf = 1'b0;
    logic [31:0] m_data = 32'd0;
    logic [31:0] m_pc = 32'd0;
    int          m_count = 0;
    int          m_wait = 0;
    logic [31:0] pc_next = 32'd0;
    logic [31:0] redir_tgt = 32'd0;

    // Compare DUT against the model mid-cycle, then advance model and PC register.
    always @(negedge clk) begin : compare
        logic active, e_br, e_wr, e_inc, e_req;
        active = !reset && !m_idle && !m_err;
        e_br   = active && redirect_valid && redirect_is_imm;
        e_wr   = active && redirect_valid && !redirect_is_imm;
        e_inc  = !reset && m_fetching && imem_ack && !redirect_valid;
        e_req  = !reset && m_fetching;

        chk("pc_branch", 32'(pc_branch), 32'(e_br));
        chk("pc_write_en", 32'(pc_write_en), 32'(e_wr));
        chk("pc_incr_en", 32'(pc_incr_en), 32'(e_inc));
        chk("imem_req", 32'(imem_req), 32'(e_req));
        if (e_req) chk("imem_addr", imem_addr, pc_value);
        chk("instr_valid", 32'(instr_valid), 32'(m_buf));
        chk("instr_data", instr_data, m_data);
        chk("instr_pc", instr_pc, m_pc);
        chk("fetch_err", 32'(fetch_err), 32'(m_err));
        chk("fetch_count", 32'(fetch_count), 32'(m_count % (1 << CNT_W)));
        chk("stale_word_seen", 32'(instr_data == STALE), 32'd0);

        if (e_br || e_wr)
            pc_next = redir_tgt;
        else if (e_inc)
            pc_next = pc_value + 32'd4;
        else
            pc_next = pc_value;

        if (reset) begin
            m_idle = 1'b1; m_fetching = 1'b0; m_draining = 1'b0; m_halted = 1'b0;
            m_err = 1'b0; m_buf = 1'b0; m_data = 32'd0; m_pc = 32'd0;
            m_count = 0; m_wait = 0;
        end else if (m_idle) begin
            m_idle = 1'b0;
            if (halt) m_halted = 1'b1;
            else begin m_fetching = 1'b1; m_wait = 0; end
        end else if (m_err) begin
            m_err = 1'b1;
        end else if (m_fetching) begin
            if (redirect_valid) begin
                m_fetching = imem_ack;
                m_draining = !imem_ack;
                m_wait = 0;
            end else if (imem_ack) begin
                m_buf = 1'b1; m_data = imem_rdata; m_pc = pc_value;
                m_fetching = 1'b0;
            end else begin
                m_wait++;
                if (m_wait == TIMEOUT) begin m_err = 1'b1; m_fetching = 1'b0; end
            end
        end else if (m_buf) begin
            if (redirect_valid) begin
                m_buf = 1'b0; m_fetching = 1'b1; m_wait = 0;
            end else if (instr_ready) begin
                m_buf = 1'b0;
                m_count++;
                if (halt) m_halted = 1'b1;
                else begin m_fetching = 1'b1; m_wait = 0; end
            end
        end else if (m_draining) begin
            if (imem_ack) begin
                m_draining = 1'b0; m_fetching = 1'b1; m_wait = 0;
            end else begin
                m_wait++;
                if (m_wait == TIMEOUT) begin m_err = 1'b1; m_draining = 1'b0; end
            end
        end else if (m_halted) begin
            if (!halt) begin m_halted = 1'b0; m_fetching = 1'b1; m_wait = 0; end
        end
    end

    // One clock of stimulus; returns mid-cycle so outputs can be inspected.
    task automatic cyc(input logic rst, input logic ack, input logic rdy,
                       input logic rdr, input logic imm, input logic hlt,
                       input logic stale);
        @(posedge clk); #1;
        reset           = rst;
        pc_value        = pc_next;
        imem_ack        = ack;
        imem_rdata      = ack ? (stale ? STALE : mem_word(pc_next)) : 32'd0;
        instr_ready     = rdy;
        redirect_valid  = rdr;
        redirect_is_imm = imm;
        halt            = hlt;
        @(negedge clk); #1;
    endtask

    // Directed scenarios with hand-computed literal expectations.
    initial begin
        int req_cnt;
        cyc(1, 0, 0, 0, 0, 0, 0);
        cyc(0, 0, 0, 0, 0, 0, 0);
        chk("idle_no_req", 32'(imem_req), 32'd0);
        chk("reset_count", 32'(fetch_count), 32'd0);
        chk("reset_valid", 32'(instr_valid), 32'd0);

        // Zero-wait memory, decode always ready.
        for (int i = 0; i < 3; i++) begin
            cyc(0, 1, 1, 0, 0, 0, 0);
            chk("zw_incr", 32'(pc_incr_en), 32'd1);
            chk("zw_addr", imem_addr, 32'(4 * i));
            cyc(0, 0, 1, 0, 0, 0, 0);
            chk("zw_gap", 32'(pc_incr_en), 32'd0);
            chk("zw_instr_pc", instr_pc, 32'(4 * i));
        end
        cyc(0, 1, 0, 0, 0, 0, 0);
        chk("zw_count", 32'(fetch_count), 32'd3);

        // Decode backpressure for 5 cycles.
        for (int i = 0; i < 5; i++) begin
            cyc(0, 0, 0, 0, 0, 0, 0);
            chk("bp_valid", 32'(instr_valid), 32'd1);
            chk("bp_pc", instr_pc, 32'd12);
            chk("bp_data", instr_data, mem_word(32'd12));
            chk("bp_req", 32'(imem_req), 32'd0);
        end
        cyc(0, 0, 1, 0, 0, 0, 0);

        // Immediate redirect in FETCH, stale ack three cycles later.
        redir_tgt = 32'h100;
        cyc(0, 0, 0, 1, 1, 0, 0);
        chk("rd_branch", 32'(pc_branch), 32'd1);
        chk("rd_addr", imem_addr, 32'd16);
        cyc(0, 0, 0, 0, 0, 0, 0);
        chk("drain_req", 32'(imem_req), 32'd0);
        cyc(0, 0, 0, 0, 0, 0, 0);
        cyc(0, 1, 0, 0, 0, 0, 1);
        cyc(0, 1, 1, 0, 0, 0, 0);
        chk("rd_new_addr", imem_addr, 32'h100);
        cyc(0, 0, 1, 0, 0, 0, 0);
        chk("rd_instr_pc", instr_pc, 32'h100);
        chk("rd_instr_data", instr_data, mem_word(32'h100));

        // Register-write redirect together with an ack.
        redir_tgt = 32'h200;
        cyc(0, 1, 0, 1, 0, 0, 1);
        chk("rw_write", 32'(pc_write_en), 32'd1);
        chk("rw_no_incr", 32'(pc_incr_en), 32'd0);
        cyc(0, 1, 0, 0, 0, 0, 0);
        chk("rw_refetch", imem_addr, 32'h200);
        chk("rw_discard", 32'(instr_valid), 32'd0);

        // Redirect and instr_ready in the same ISSUE cycle.
        redir_tgt = 32'h300;
        cyc(0, 0, 1, 1, 1, 0, 0);
        chk("ri_valid", 32'(instr_valid), 32'd1);
        cyc(0, 0, 0, 0, 0, 0, 0);
        chk("ri_cleared", 32'(instr_valid), 32'd0);
        chk("ri_count", 32'(fetch_count), 32'd5);

        // Halt during FETCH completes the fetch and issue, then parks.
        cyc(0, 1, 0, 0, 0, 1, 0);
        cyc(0, 0, 1, 0, 0, 1, 0);
        cyc(0, 0, 0, 0, 0, 1, 0);
        chk("halt_req", 32'(imem_req), 32'd0);
        chk("halt_count", 32'(fetch_count), 32'd6);
        redir_tgt = 32'h400;
        cyc(0, 0, 0, 1, 0, 1, 0);
        chk("halt_redirect", 32'(pc_write_en), 32'd1);
        cyc(0, 0, 0, 0, 0, 0, 0);
        cyc(0, 1, 1, 0, 0, 0, 0);
        chk("halt_resume", imem_addr, 32'h400);
        cyc(0, 0, 1, 0, 0, 0, 0);

        // Counter wrap (3-bit): 7 -> 0 -> 1.
        for (int i = 0; i < 2; i++) begin
            cyc(0, 1, 1, 0, 0, 0, 0);
            cyc(0, 0, 1, 0, 0, 0, 0);
        end

        // Memory never acks: timeout then terminal error.
        req_cnt = 0;
        for (int i = 0; i < 8; i++) begin
            cyc(0, i >= 6, 0, i >= 6, 0, 0, 1);
            if (i == 0) chk("wrap_count", 32'(fetch_count), 32'd1);
            req_cnt += int'(imem_req);
        end
        chk("to_req_cycles", 32'(req_cnt), 32'd4);
        chk("to_err", 32'(fetch_err), 32'd1);
        chk("to_req_off", 32'(imem_req), 32'd0);

        // Reset clears the error; a stray ack in IDLE is ignored.
        cyc(1, 0, 0, 0, 0, 0, 0);
        cyc(0, 1, 0, 0, 0, 0, 1);
        chk("rst_err", 32'(fetch_err), 32'd0);
        chk("rst_count", 32'(fetch_count), 32'd0);
        chk("rst_stray_ack", 32'(pc_incr_en), 32'd0);
        cyc(0, 1, 1, 0, 0, 0, 0);
        chk("rst_refetch", 32'(pc_incr_en), 32'd1);

        // Reset mid-operation gives no strobes.
        cyc(1, 1, 1, 1, 0, 0, 0);
        chk("rst_mid_strobe", 32'(pc_write_en), 32'd0);
        cyc(0, 0, 0, 0, 0, 0, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
